dm_write_tracer: RTL
====================

DM_WRITE_TRACER -- requirements
Module: dm_write_tracer

Interface
REQ-001 The block SHALL have parameter N, default 64: data-memory address and data width.
REQ-002 The block SHALL have parameter DEPTH, default 16: trace buffer entries; a power of two, at least 2.
REQ-003 The block SHALL have parameter TS_W, default 16: timestamp width.
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port DM_writeEnable, input, 1 bit: processor data-memory write strobe.
REQ-007 The block SHALL have port DM_addr, input, N bits: write address.
REQ-008 The block SHALL have port DM_writeData, input, N bits: write data.
REQ-009 The block SHALL have port dump, input, 1 bit: drain request, level.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a trace entry is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the entry.
REQ-012 The block SHALL have ports out_addr (N bits), out_data (N bits) and out_ts (TS_W bits), all outputs: the presented entry.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, at least one write dropped.
REQ-015 The block SHALL have port draining, output, 1 bit: high while in the DRAIN state.

Function
REQ-016 The block SHALL implement three states: CAPTURE, DRAIN and DONE.
REQ-017 In CAPTURE, the timestamp counter SHALL increment by 1 each cycle and wrap modulo 2^TS_W.
REQ-018 In CAPTURE, a cycle with DM_writeEnable=1 and count<DEPTH SHALL push {ts, DM_addr, DM_writeData}; count SHALL update on the next edge.
REQ-019 In CAPTURE, DM_writeEnable=1 with count=DEPTH SHALL drop the write and set overflow; overflow SHALL stay set until reset or DONE->CAPTURE.
REQ-020 The transition CAPTURE->DRAIN SHALL occur on the edge where dump is sampled high after being low in the previous cycle (rising edge detected internally).
REQ-021 A write in that same transition cycle SHALL still be captured, subject to REQ-019.
REQ-022 In DRAIN, DM_writeEnable SHALL be ignored, the timestamp SHALL hold, and out_valid SHALL equal (count!=0).
REQ-023 In DRAIN, the out_* outputs SHALL present the oldest entry, with zero added latency (FIFO head, not a registered pop).
REQ-024 An entry SHALL be popped on each cycle with out_valid & out_ready.
REQ-025 While out_valid=1 and out_ready=0, the out_* outputs SHALL remain stable.
REQ-026 In DRAIN, when count=0 (including DRAIN entered empty), the state SHALL go to DONE on the next edge.
REQ-027 DONE SHALL hold while dump=1.
REQ-028 When dump=0 in DONE, the state SHALL move to CAPTURE and clear overflow and the timestamp.
REQ-029 Outside DRAIN, out_valid SHALL be 0 and out_* SHALL be don't-care.
REQ-030 The read and write pointers SHALL be $clog2(DEPTH) bits wide, wrap naturally, and use count to disambiguate full from empty.

Reset
REQ-031 While reset=0, asynchronously: the state SHALL be CAPTURE; pointers, count and timestamp SHALL be 0; overflow=0; out_valid=0; draining=0; the dump edge register SHALL be 0.
REQ-032 Asserting reset mid-DRAIN SHALL discard all entries and take effect immediately.
REQ-033 Buffer storage SHALL not be reset.

Structure
REQ-034 Package dm_trace_pkg SHALL hold the state enum (CAPTURE, DRAIN, DONE) and the parametrised-width entry field-order constants.
REQ-035 A single sub-module, trace_fifo, SHALL provide the synchronous FIFO (push, pop, head, count) with the same clock and reset.
REQ-036 The state machine, timestamp counter, edge detector and overflow flag SHALL reside in dm_write_tracer.

Verification
REQ-037 Scenario: after reset, writes at ts 3, 5 and 9 (addr 0x8/0x10/0x18, data 0xA/0xB/0xC); dump rises; out_ready=1 -> three beats in order with out_ts 3/5/9, then DONE, count=0.
REQ-038 Scenario: DEPTH=4, 6 consecutive writes -> count=4, overflow=1; drain returns the first 4 only.
REQ-039 Scenario: out_ready toggling 1,0,0,1 during drain -> out_* stable across the stalled cycles; no entry lost or duplicated.
REQ-040 Scenario: write in the same cycle as the dump rise, then writes during DRAIN -> only the coincident write is captured.
REQ-041 Scenario: TS_W=4, first write at cycle 17 after reset -> out_ts=1 (wrap).
REQ-042 Scenario: reset=0 mid-drain with 2 entries left -> out_valid=0 and count=0 immediately; dump low -> fresh capture starts at ts 0.

Source files
------------

// File: rtl/dm_trace_pkg.sv
// -----------------------------------------------------------------------------
// dm_trace_pkg
// Shared definitions for the data-memory write tracer:
//   - state_e       : tracer states (CAPTURE, DRAIN, DONE)
//   - entry layout  : helpers giving the width of one trace entry and the LSB
//                     position of each field.
//                     Field order, LSB first: write data, write address,
//                     timestamp, i.e. entry = {ts, addr, data}.
// -----------------------------------------------------------------------------
package dm_trace_pkg;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } state_e;

   // Total width of one entry for address/data width n and timestamp width ts_w
   function automatic int unsigned entry_w(input int unsigned n, input int unsigned ts_w);
      return (2 * n) + ts_w;
   endfunction

   // LSB of the write-data field
   function automatic int unsigned data_lsb(input int unsigned n);
      return 0 * n;
   endfunction

   // LSB of the write-address field
   function automatic int unsigned addr_lsb(input int unsigned n);
      return n;
   endfunction

   // LSB of the timestamp field
   function automatic int unsigned ts_lsb(input int unsigned n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding trace entries. The head entry is read straight from
// storage, so it is visible in the same cycle it becomes the oldest entry.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (pointers and count only)
//   push_i   : write wdata_i (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   wdata_i  : entry to write
//   head_o   : oldest entry
//   count_o  : occupancy, 0..DEPTH
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
// -----------------------------------------------------------------------------
module trace_fifo #(
   parameter  int unsigned W     = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok_s, pop_ok_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == {CW{1'b0}});
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;
   assign head_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Next pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/dm_write_tracer.sv
// -----------------------------------------------------------------------------
// dm_write_tracer
// Records processor data-memory writes as {timestamp, address, data} entries
// while capturing, then drains them oldest-first over a valid/ready port when
// a rising edge is seen on dump.
// Ports:
//   CLOCK_50                : clock, rising edge
//   reset                   : asynchronous active-low reset
//   DM_writeEnable/DM_addr/DM_writeData : observed data-memory write
//   dump                    : drain request (level; its rising edge starts a drain)
//   out_valid/out_ready     : drain handshake
//   out_addr/out_data/out_ts: presented (oldest) entry
//   count                   : buffer occupancy
//   overflow                : sticky, at least one write was dropped
//   draining                : high while in DRAIN
// -----------------------------------------------------------------------------
module dm_write_tracer
   import dm_trace_pkg::*;
#(
   parameter  int unsigned N     = 64,
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned TS_W  = 16,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic            DM_writeEnable,
   input  logic [N-1:0]    DM_addr,
   input  logic [N-1:0]    DM_writeData,
   input  logic            dump,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_addr,
   output logic [N-1:0]    out_data,
   output logic [TS_W-1:0] out_ts,
   output logic [CW-1:0]   count,
   output logic            overflow,
   output logic            draining
);

   localparam int unsigned EW     = entry_w(N, TS_W);
   localparam int unsigned D_LSB  = data_lsb(N);
   localparam int unsigned A_LSB  = addr_lsb(N);
   localparam int unsigned T_LSB  = ts_lsb(N);

   state_e          state_q, state_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            overflow_q, overflow_d;
   logic            dump_q;
   logic            dump_rise_s;
   logic            push_s, pop_s;
   logic            full_s, empty_s;
   logic [EW-1:0]   entry_s, head_s;

   assign dump_rise_s = dump & ~dump_q;
   // Writes are only recorded while capturing; the dump-rise cycle still counts
   assign push_s      = (state_q == CAPTURE) & DM_writeEnable & ~full_s;
   assign pop_s       = (state_q == DRAIN) & ~empty_s & out_ready;

   // Pack the incoming write into the entry layout
   always_comb begin
      entry_s                  = {EW{1'b0}};
      entry_s[D_LSB +: N]      = DM_writeData;
      entry_s[A_LSB +: N]      = DM_addr;
      entry_s[T_LSB +: TS_W]   = ts_q;
   end

   trace_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLOCK_50),
      .rst_ni  (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (entry_s),
      .head_o  (head_s),
      .count_o (count),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // Next state, timestamp and overflow
   always_comb begin
      state_d    = state_q;
      ts_d       = ts_q;
      overflow_d = overflow_q;
      case (state_q)
         CAPTURE: begin
            ts_d = ts_q + TS_W'(1);
            if (DM_writeEnable && full_s) begin
               overflow_d = 1'b1;
            end else begin
               overflow_d = overflow_q;
            end
            if (dump_rise_s) begin
               state_d = DRAIN;
            end else begin
               state_d = CAPTURE;
            end
         end
         DRAIN: begin
            if (empty_s) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            if (!dump) begin
               state_d    = CAPTURE;
               overflow_d = 1'b0;
               ts_d       = {TS_W{1'b0}};
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = CAPTURE;
         end
      endcase
   end

   // State, timestamp, overflow and dump-edge registers
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q    <= CAPTURE;
         ts_q       <= {TS_W{1'b0}};
         overflow_q <= 1'b0;
         dump_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         dump_q     <= dump;
      end
   end

   assign draining  = (state_q == DRAIN);
   assign out_valid = draining & ~empty_s;
   assign out_data  = head_s[D_LSB +: N];
   assign out_addr  = head_s[A_LSB +: N];
   assign out_ts    = head_s[T_LSB +: TS_W];
   assign overflow  = overflow_q;

endmodule
